sha256_cme_sched_ctrl: RTL

Iterative message-schedule sequencer for the second SHA-256 pass of the double-hash datapath. It accepts the 256-bit first-pass digest and builds the padded second block internally: eight digest words, pad word, six zero words, length word. It then issues W0..W63 one word per handshake to the round engine. A 16-word sliding window produces each expanded word W16..W63 on the fly, with valid/ready backpressure and a completion pulse.

---
 rtl/sha256_cme_sched_ctrl_if.sv | 26 ++
 rtl/sha256_cme_sched_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/sha256_cme_sched_ctrl_if.sv
// Digest-in / schedule-word-out handshake bundle for the SHA-256 second-pass scheduler.
// Latency: none (wires only).
// Backpressure: valid/ready on both the start and the word channel.
interface sha256_cme_sched_ctrl_if;
    logic         start_valid;
    logic         start_ready;
    logic [255:0] digest_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_out;
    logic [5:0]   w_idx;
    logic         w_last;
    logic         done;

    // Producer of digests and consumer of schedule words.
    modport master (
        output start_valid, digest_in, w_ready,
        input  start_ready, w_valid, w_out, w_idx, w_last, done
    );

    // The scheduler itself.
    modport slave (
        input  start_valid, digest_in, w_ready,
        output start_ready, w_valid, w_out, w_idx, w_last, done
    );
endinterface

// File: rtl/sha256_cme_sched_ctrl.sv
// Message-schedule sequencer for the second SHA-256 pass: emits W0..W63 from a 16-word sliding window.
// Latency: first word one cycle after the start handshake; one word per cycle; done one cycle after W63.
// Backpressure: w_ready low freezes window, index and outputs; start is only taken while idle.
module sha256_cme_sched_ctrl #(
    parameter logic [31:0] W8_PAD  = 32'h80000000,
    parameter logic [31:0] W15_LEN = 32'h00000100
) (
    input  logic                    CLK,
    input  logic                    RST,
    sha256_cme_sched_ctrl_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [31:0] win [16];
    logic        done_q;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next expanded word from the pre-shift window; only feeds the window, never w_out.
    always_comb begin
        w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
    end

    // Handshake flags come from the state register alone; start_ready is held low during reset.
    assign bus.start_ready = (state == IDLE) && !RST;
    assign bus.w_valid     = (state == RUN);
    assign bus.w_out       = win[0];
    assign bus.w_idx       = idx;
    assign bus.w_last      = (state == RUN) && (idx == 6'd63);
    assign bus.done        = done_q;

    // Sequencer: load the padded block, then shift the window once per accepted word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            idx    <= 6'd0;
            done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        for (int i = 0; i < 8; i++) begin
                            win[i] <= bus.digest_in[255 - 32*i -: 32];
                        end
                        win[8] <= W8_PAD;
                        for (int i = 9; i < 15; i++) begin
                            win[i] <= 32'd0;
                        end
                        win[15] <= W15_LEN;
                        idx     <= 6'd0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.w_ready) begin
                        for (int i = 0; i < 15; i++) begin
                            win[i] <= win[i+1];
                        end
                        win[15] <= w_new;
                        // idx stays at 63 on the final word so it never wraps inside RUN.
                        if (idx == 6'd63) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
